// File: rtl/atm_dut_pkg.sv
// Shared types and helpers for the ATM transaction controller.
//   state_e    : controller session states
//   AMT_*      : denomination codes presented on the amount input
//   amt_units  : denomination code -> balance units of 50000
package atm_dut_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StWaitPin = 2'd1,
    StSelect  = 2'd2,
    StDone    = 2'd3
  } state_e;

  localparam logic [1:0] AMT_NONE = 2'b00;
  localparam logic [1:0] AMT_50K  = 2'b01;
  localparam logic [1:0] AMT_100K = 2'b10;
  localparam logic [1:0] AMT_200K = 2'b11;

  // Width of a unit count; the largest denomination is 4 units.
  localparam int unsigned UnitW = 3;

  function automatic logic [UnitW-1:0] amt_units(input logic [1:0] amt);
    logic [UnitW-1:0] units;
    case (amt)
      AMT_50K:  units = 3'd1;
      AMT_100K: units = 3'd2;
      AMT_200K: units = 3'd4;
      default:  units = 3'd0;
    endcase
    return units;
  endfunction

endpackage

// File: rtl/atm_balance.sv
// Account balance register with check-and-update.
//   clk_i      : clock, rising edge
//   rst_i      : synchronous active-high reset, loads INIT_BALANCE
//   req_i      : apply a transaction this cycle
//   withdraw_i : 1 = withdraw, 0 = deposit
//   units_i    : transaction size in units of 50000
//   ok_o       : combinational verdict for the presented request (no underflow / overflow)
module atm_balance
  import atm_dut_pkg::*;
#(
  parameter int unsigned BAL_W        = 8,
  parameter int unsigned INIT_BALANCE = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_i,
  input  logic             withdraw_i,
  input  logic [UnitW-1:0] units_i,
  output logic             ok_o
);

  logic [BAL_W-1:0] bal_q, bal_d;
  logic [BAL_W:0]   units_ext;
  logic [BAL_W:0]   sum;
  logic [BAL_W:0]   diff;

  // One extra bit catches the deposit carry and the withdraw borrow.
  assign units_ext = (BAL_W+1)'(units_i);
  assign sum       = {1'b0, bal_q} + units_ext;
  assign diff      = {1'b0, bal_q} - units_ext;

  assign ok_o = withdraw_i ? ~diff[BAL_W] : ~sum[BAL_W];

  always_comb begin
    bal_d = bal_q;
    if (req_i && ok_o) begin
      bal_d = withdraw_i ? diff[BAL_W-1:0] : sum[BAL_W-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bal_q <= BAL_W'(INIT_BALANCE);
    end else begin
      bal_q <= bal_d;
    end
  end

endmodule

// File: rtl/atm_dut.sv
// Single-account ATM transaction controller: card -> PIN -> select -> done, one
// transaction per card insertion, with a one-cycle registered pulse on the
// matching withdraw/deposit actuator output.
//   clock, reset : clock and synchronous active-high reset
//   card, PIN    : card-present and PIN-verified levels
//   amount       : denomination code (00 none, 01 50k, 10 100k, 11 200k)
//   choice       : 1 withdraw, 0 deposit (sampled with a nonzero amount in select)
//   W_* / D_*    : one-cycle withdraw / deposit pulses, at most one high
module atm_dut
  import atm_dut_pkg::*;
#(
  parameter int unsigned BAL_W        = 8,
  parameter int unsigned INIT_BALANCE = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       card,
  input  logic       PIN,
  input  logic [1:0] amount,
  input  logic       choice,
  output logic       W_50000,
  output logic       W_100000,
  output logic       W_200000,
  output logic       D_50000,
  output logic       D_100000,
  output logic       D_200000
);

  state_e     state_q, state_d;
  // Bit order: {D_200000, D_100000, D_50000, W_200000, W_100000, W_50000}
  logic [5:0] pulse_q, pulse_d;
  logic [2:0] denom;
  logic       txn_req;
  logic       bal_ok;

  atm_balance #(
    .BAL_W        (BAL_W),
    .INIT_BALANCE (INIT_BALANCE)
  ) u_balance (
    .clk_i      (clock),
    .rst_i      (reset),
    .req_i      (txn_req),
    .withdraw_i (choice),
    .units_i    (amt_units(amount)),
    .ok_o       (bal_ok)
  );

  always_comb begin
    denom = 3'b000;
    case (amount)
      AMT_50K:  denom = 3'b001;
      AMT_100K: denom = 3'b010;
      AMT_200K: denom = 3'b100;
      default:  denom = 3'b000;
    endcase
  end

  always_comb begin
    state_d = state_q;
    txn_req = 1'b0;
    pulse_d = 6'b000000;
    // Card removal aborts any session and wins over a same-edge selection.
    if (state_q != StIdle && !card) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:    if (card) state_d = StWaitPin;
        StWaitPin: if (PIN) state_d = StSelect;
        StSelect: begin
          if (amount != AMT_NONE) begin
            txn_req = 1'b1;
            state_d = StDone;
            if (bal_ok) begin
              pulse_d = choice ? {3'b000, denom} : {denom, 3'b000};
            end
          end
        end
        StDone:    state_d = StDone;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      pulse_q <= 6'b000000;
    end else begin
      state_q <= state_d;
      pulse_q <= pulse_d;
    end
  end

  assign W_50000  = pulse_q[0];
  assign W_100000 = pulse_q[1];
  assign W_200000 = pulse_q[2];
  assign D_50000  = pulse_q[3];
  assign D_100000 = pulse_q[4];
  assign D_200000 = pulse_q[5];

endmodule

// File: tb/tb_atm_dut.sv
module tb_atm_dut;

  localparam int BalMax  = 255;
  localparam int InitBal = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       card = 1'b0;
  logic       PIN = 1'b0;
  logic [1:0] amount = 2'b00;
  logic       choice = 1'b0;
  logic       W_50000, W_100000, W_200000, D_50000, D_100000, D_200000;
  logic [5:0] dut_vec;

  int n_checks = 0;
  int n_fail   = 0;

  atm_dut dut (
    .clock    (clock),
    .reset    (reset),
    .card     (card),
    .PIN      (PIN),
    .amount   (amount),
    .choice   (choice),
    .W_50000  (W_50000),
    .W_100000 (W_100000),
    .W_200000 (W_200000),
    .D_50000  (D_50000),
    .D_100000 (D_100000),
    .D_200000 (D_200000)
  );

  always #10 clock = ~clock;

  // {D200, D100, D50, W200, W100, W50}
  assign dut_vec = {D_200000, D_100000, D_50000, W_200000, W_100000, W_50000};

  // Session model: 0 idle, 1 awaiting PIN, 2 choosing, 3 transaction used up.
  int         m_phase = 0;
  int         m_bal   = 0;
  bit         m_live  = 1'b0;
  logic [5:0] m_exp   = 6'b000000;

  always @(posedge clock) begin
    logic [5:0] e;
    int         u;
    int         idx;
    e = 6'b000000;
    if (reset) begin
      m_phase = 0;
      m_bal   = InitBal;
      m_live  = 1'b1;
    end else if (m_phase != 0 && !card) begin
      m_phase = 0;
    end else begin
      case (m_phase)
        0: if (card) m_phase = 1;
        1: if (PIN) m_phase = 2;
        2: if (amount != 2'b00) begin
          u   = (amount == 2'b11) ? 4 : int'(amount);
          idx = int'(amount) - 1;
          if (choice) begin
            if (m_bal >= u) begin
              m_bal  = m_bal - u;
              e[idx] = 1'b1;
            end
          end else if (m_bal + u <= BalMax) begin
            m_bal      = m_bal + u;
            e[3 + idx] = 1'b1;
          end
          m_phase = 3;
        end
        default: ;
      endcase
    end
    m_exp = e;
  end

  always @(negedge clock) begin
    if (m_live) begin
      n_checks++;
      if (dut_vec !== m_exp) begin
        n_fail++;
        $display("FAIL cycle_compare t=%0t outputs got=%b want=%b", $time, dut_vec, m_exp);
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic drive(input logic r, input logic c, input logic p, input logic ch,
                       input logic [1:0] a);
    @(negedge clock);
    reset  = r;
    card   = c;
    PIN    = p;
    choice = ch;
    amount = a;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
  endtask

  // Full session; seen holds the outputs in the cycle after the selection edge.
  task automatic session(input logic ch, input logic [1:0] a, output logic [5:0] seen);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 2'b00);
    drive(1'b0, 1'b1, 1'b1, ch, a);
    @(negedge clock);
    seen = dut_vec;
    drive(1'b0, 1'b1, 1'b1, ch, a);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
  endtask

  initial begin
    logic [5:0] seen;

    do_reset();
    chk("reset_outputs", int'(dut_vec), 0);
    chk("reset_model_balance", m_bal, 4);

    // Basic withdraw 50000, then inputs held in DONE.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 2'b00);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 2'b01);
    @(negedge clock);
    chk("w50k_pulse", int'(dut_vec), 6'b000001);
    chk("w50k_balance", m_bal, 3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("held_no_repeat", int'(dut_vec), 0);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);

    // Withdraw 200000 from 4, then rejected withdraw at zero.
    do_reset();
    session(1'b1, 2'b11, seen);
    chk("w200k_pulse", int'(seen), 6'b000100);
    chk("w200k_balance", m_bal, 0);
    session(1'b1, 2'b01, seen);
    chk("w_reject_zero", int'(seen), 0);
    chk("w_reject_balance", m_bal, 0);

    // Deposit 100000.
    session(1'b0, 2'b10, seen);
    chk("d100k_pulse", int'(seen), 6'b010000);
    chk("d100k_balance", m_bal, 2);

    // Card drop in WAIT_PIN.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 2'b01);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 2'b01);
    @(negedge clock);
    chk("drop_waitpin", int'(dut_vec), 0);

    // Card drop in SELECT with amount on the same edge.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 2'b00);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 2'b01);
    @(negedge clock);
    chk("drop_select", int'(dut_vec), 0);

    // Re-insert with amount already present: nothing until PIN, then fire.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 2'b01);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 2'b01);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 2'b01);
    chk("no_pin_no_pulse", int'(dut_vec), 0);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 2'b01);
    @(negedge clock);
    chk("select_entry_quiet", int'(dut_vec), 0);
    @(negedge clock);
    chk("early_amount_fires", int'(dut_vec), 6'b000001);
    chk("early_amount_balance", m_bal, 1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);

    // Reset in SELECT with a pending amount.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 2'b00);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 2'b01);
    @(negedge clock);
    chk("reset_in_select", int'(dut_vec), 0);
    chk("reset_in_select_bal", m_bal, 4);

    // Reset in DONE while the pulse is showing.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 2'b00);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 2'b00);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 2'b10);
    @(negedge clock);
    chk("w100k_pulse", int'(dut_vec), 6'b000010);
    reset = 1'b1;
    @(negedge clock);
    chk("reset_in_done", int'(dut_vec), 0);
    chk("reset_in_done_bal", m_bal, 4);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);

    // Fill to 254, then overflow boundary.
    for (int i = 0; i < 62; i++) session(1'b0, 2'b11, seen);
    session(1'b0, 2'b10, seen);
    chk("fill_balance", m_bal, 254);
    session(1'b0, 2'b11, seen);
    chk("d_overflow_reject", int'(seen), 0);
    chk("d_overflow_balance", m_bal, 254);
    session(1'b0, 2'b01, seen);
    chk("d50k_to_max", int'(seen), 6'b001000);
    session(1'b0, 2'b01, seen);
    chk("d_at_max_reject", int'(seen), 0);
    session(1'b1, 2'b11, seen);
    chk("w200k_from_max", int'(seen), 6'b000100);
    chk("final_balance", m_bal, 251);

    repeat (2) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
